// File: rtl/life_video_streamer.sv
// Game of Life pixel streamer: fetches grid rows from ping-pong line buffers and emits AXI4-Stream video.
// Optional grid overlay enabled by defining LIFE_STREAM_GRID_OVERLAY_EN (adds parameter GRID_RGB).
module life_video_streamer #(
  parameter int unsigned X_SIZE     = 1280,
  parameter int unsigned Y_SIZE     = 720,
  parameter int unsigned CELL_SHIFT = 0,
  parameter int unsigned ROW_W      = X_SIZE >> CELL_SHIFT,
  parameter int unsigned ADDR_W     = ((Y_SIZE >> CELL_SHIFT) > 1) ? $clog2(Y_SIZE >> CELL_SHIFT) : 1
`ifdef LIFE_STREAM_GRID_OVERLAY_EN
  , parameter logic [23:0] GRID_RGB = 24'h202020
`endif
) (
  input  logic              out_stream_aclk,
  input  logic              periph_resetn,
  input  logic              enable,
  input  logic [23:0]       alive_rgb,
  input  logic [23:0]       dead_rgb,
  input  logic              buf_sel_req,
  output logic              buf_sel,
  output logic              row_rd_en,
  output logic              row_rd_buf,
  output logic [ADDR_W-1:0] row_rd_addr,
  input  logic [ROW_W-1:0]  row_rd_data,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [31:0]       out_stream_tdata,
  output logic [3:0]        out_stream_tkeep,
  output logic              out_stream_tlast,
  output logic              out_stream_tuser,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready
);

  localparam int unsigned XW = $clog2(X_SIZE);
  localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  localparam logic [YW-1:0] Y_CELL_MASK = YW'((1 << CELL_SHIFT) - 1);
`ifdef LIFE_STREAM_GRID_OVERLAY_EN
  localparam logic [XW-1:0] X_CELL_MASK = XW'((1 << CELL_SHIFT) - 1);
`endif

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t            state;
  logic [ROW_W-1:0]  cur_row;
  logic [ROW_W-1:0]  nxt_row;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;

  logic              beat_accept;
  logic              line_end;
  logic              frame_end;
  logic              row_end;
  logic [XW-1:0]     nx;
  logic [YW-1:0]     ny;
  logic [ROW_W-1:0]  nrow;
  logic [ROW_W-1:0]  next_aligned;
  logic [ROW_W-1:0]  first_aligned;
  logic [23:0]       next_rgb;
  logic [23:0]       first_rgb;

  assign out_stream_tkeep = 4'hF;
  assign row_rd_buf       = buf_sel;

  assign beat_accept = out_stream_tvalid & out_stream_tready;
  assign line_end    = (x == X_LAST);
  assign frame_end   = line_end && (y == Y_LAST);
  // Last line of a cell row that has a following cell row: fetch the next one during it.
  assign row_end     = ((y & Y_CELL_MASK) == Y_CELL_MASK) && (y != Y_LAST);

  // Coordinates and colour of the beat that follows the current one.
  always_comb begin
    nx            = line_end ? '0 : x + XW'(1);
    ny            = line_end ? y + YW'(1) : y;
    nrow          = (line_end && row_end) ? nxt_row : cur_row;
    next_aligned  = nrow << (nx >> CELL_SHIFT);
    first_aligned = row_rd_data;
    next_rgb      = next_aligned[ROW_W-1] ? alive_rgb : dead_rgb;
    first_rgb     = first_aligned[ROW_W-1] ? alive_rgb : dead_rgb;
`ifdef LIFE_STREAM_GRID_OVERLAY_EN
    if (CELL_SHIFT >= 2) begin
      if (((nx & X_CELL_MASK) == '0) || ((ny & Y_CELL_MASK) == '0)) next_rgb = GRID_RGB;
      first_rgb = GRID_RGB;
    end
`endif
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      state             <= IDLE;
      cur_row           <= '0;
      nxt_row           <= '0;
      x                 <= '0;
      y                 <= '0;
      buf_sel           <= 1'b0;
      row_rd_en         <= 1'b0;
      row_rd_addr       <= '0;
      frame_done        <= 1'b0;
      frame_count       <= 16'd0;
      out_stream_tdata  <= 32'd0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
      out_stream_tvalid <= 1'b0;
    end else begin
      row_rd_en  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= LOAD;
            buf_sel     <= buf_sel_req;
            row_rd_en   <= 1'b1;
            row_rd_addr <= '0;
          end
        end
        LOAD: begin
          state             <= STREAM;
          cur_row           <= row_rd_data;
          x                 <= '0;
          y                 <= '0;
          out_stream_tvalid <= 1'b1;
          out_stream_tuser  <= 1'b1;
          out_stream_tlast  <= 1'b0;
          out_stream_tdata  <= {8'h00, first_rgb};
        end
        STREAM: begin
          if (row_rd_en) nxt_row <= row_rd_data;
          if (beat_accept) begin
            if ((x == '0) && row_end) begin
              row_rd_en   <= 1'b1;
              row_rd_addr <= ADDR_W'(y >> CELL_SHIFT) + ADDR_W'(1);
            end
            if (frame_end) begin
              frame_done        <= 1'b1;
              frame_count       <= frame_count + 16'd1;
              out_stream_tvalid <= 1'b0;
              out_stream_tuser  <= 1'b0;
              out_stream_tlast  <= 1'b0;
              if (enable) begin
                state       <= LOAD;
                buf_sel     <= buf_sel_req;
                row_rd_en   <= 1'b1;
                row_rd_addr <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              x                <= nx;
              y                <= ny;
              cur_row          <= nrow;
              out_stream_tuser <= 1'b0;
              out_stream_tlast <= (nx == X_LAST);
              out_stream_tdata <= {8'h00, next_rgb};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
